disp_scan_gen: RTL and testbench
================================

Name: disp_scan_gen

Overview:
- Upstream driver for the 4-digit seven-segment display multiplexer.
- Produces the three inputs that multiplexer consumes:
  - the 6-bit scan-phase counter clk_copy;
  - the 4-bit brightness threshold lighttag;
  - the 16-bit BCD word snum.
- Accepts fare BCD from the meter core over a valid/ready handshake and double-buffers it so snum changes only at a frame boundary.
- Brightness is adjusted by debounced up/down buttons.

Parameters:
- PRESCALE, 1024: clk cycles per scan-phase step; legal range 2..65535.
- DEB_CYC, 50000: consecutive stable clk cycles before a button level is accepted; legal range 2..2^20-1.
- LIGHT_RST, 15: lighttag value after reset, 0..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- bcd_in  in  16  four BCD digits; [3:0] is the rightmost digit.
- bcd_valid  in  1  bcd_in is valid this cycle.
- bcd_ready  out  1  pending buffer can accept a word.
- btn_up  in  1  raw brightness-up button, asynchronous, active-high.
- btn_down  in  1  raw brightness-down button, asynchronous, active-high.
- clk_copy  out  6  scan phase to the display mux.
- lighttag  out  4  brightness threshold to the display mux.
- snum  out  16  displayed BCD word.
- frame_start  out  1  one-cycle pulse when clk_copy wraps 63->0.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; all flops clear immediately on rst.
- Reset values:
  - clk_copy=0, lighttag=LIGHT_RST, snum=0, bcd_ready=1, frame_start=0.
  - Prescaler, pending buffer, synchronizers and debounce counters are all cleared.
- Prescaler:
  - Counts 0..PRESCALE-1 and asserts an internal tick in the cycle it equals PRESCALE-1, then returns to 0.
  - First tick occurs PRESCALE cycles after rst deasserts.
- Scan counter:
  - On tick, clk_copy <= clk_copy+1, wrapping 63->0.
  - Changes only on tick; otherwise holds.
- Frame boundary:
  - Defined as the cycle where tick=1 and clk_copy==63.
  - frame_start is registered: high for exactly one cycle, coincident with clk_copy becoming 0.
- Handshake:
  - Transfer occurs when bcd_valid && bcd_ready. bcd_in is captured into pend and pend_full is set.
  - bcd_ready = !pend_full, combinational from the register.
  - bcd_in is not checked for BCD legality; nibbles pass unchanged.
- Display update:
  - At the frame boundary, if pend_full: snum <= pend and pend_full clears, so bcd_ready rises the next cycle.
  - snum becomes visible in the same cycle clk_copy becomes 0.
  - snum never changes at any other time.
- Simultaneous events:
  - An acceptance in the frame-boundary cycle with pend empty fills pend. That word is shown at the next boundary, not this one.
  - When pend is full, bcd_ready=0, so no new word can be accepted in the same cycle as a transfer.
- Buttons:
  - Each raw button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after DEB_CYC consecutive cycles of a differing synchronized level. Any mismatch before that restarts the count.
  - A debounced 0->1 edge gives a one-cycle press pulse.
- Brightness:
  - up pulse: lighttag+1, saturating at 15.
  - down pulse: lighttag-1, saturating at 0.
  - Both pulses in the same cycle: no change.
  - Update lands in the cycle after the pulse.
- Reset mid-operation: a pending word is discarded, snum returns to 0, and the scan restarts at phase 0.
- Widths: counters are sized to their parameters; no overflow beyond stated wraps.

Decomposition:
- Package disp_pkg holds:
  - SCAN_W=6, LIGHT_W=4, DIGITS=4, BCD_W=16, LIGHT_MAX=4'd15;
  - a typedef for the 16-bit BCD word.
- Sub-module btn_debounce is instantiated twice (up, down).
  - Ports: clk, rst, raw, press.
  - Parameter: DEB_CYC.
  - Contents: synchronizer, stability counter, edge detect.

Test Plan:
- Reset / scan (PRESCALE=4): release rst -> clk_copy=0, lighttag=15, snum=0, bcd_ready=1. clk_copy increments every 4 clocks, wraps 63->0 after 256 clocks, and frame_start pulses once per 256 clocks.
- Frame-aligned update: send 16'h1234 with valid at phase 10 -> bcd_ready drops next cycle; snum stays 0 until clk_copy wraps to 0, then becomes 16'h1234 together with frame_start; bcd_ready returns to 1.
- Backpressure: hold valid with 16'h5678, then 16'h9999, across one frame -> 16'h9999 is not accepted until after the 16'h5678 transfer; snum sequence is 1234 -> 5678 -> 9999 on consecutive frames.
- Brightness saturation (DEB_CYC=8): four clean up presses from 15 -> stays 15. Sixteen down presses -> reaches 0 and stays 0. Up and down pressed together -> unchanged.
- Bounce rejection (DEB_CYC=8): btn_up toggles every 3 cycles for 40 cycles, then holds 1 for 8+ cycles -> exactly one increment.
- Async reset mid-frame: assert rst at phase 37 with pend_full -> all outputs take reset values immediately (no clock edge needed); after release, the old pending word never appears on snum.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared widths and types for the seven-segment scan generator.
package disp_pkg;
  localparam int SCAN_W  = 6;
  localparam int LIGHT_W = 4;
  localparam int DIGITS  = 4;
  localparam int BCD_W   = 16;
  localparam logic [LIGHT_W-1:0] LIGHT_MAX = 4'd15;
  localparam logic [SCAN_W-1:0]  SCAN_LAST = '1;

  typedef logic [BCD_W-1:0] bcd_word_t;
endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> stability-count debouncer -> rising-edge press pulse.
module btn_debounce #(
  parameter int DEB_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEB_CYC - 1);

  logic          sync_1, sync_2;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // The level flips on the DEB_CYC-th consecutive differing sample; any agreement restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_2 != deb) begin
      if (cnt == C_LAST) begin
        cnt <= '0;
        deb <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) deb_d <= 1'b0;
    else     deb_d <= deb;
  end

  assign press = deb && !deb_d;
endmodule

// File: rtl/disp_scan_gen.sv
// Scan-phase, brightness and frame-aligned BCD source for the 4-digit display mux.
module disp_scan_gen
  import disp_pkg::*;
#(
  parameter int PRESCALE  = 1024,
  parameter int DEB_CYC   = 50000,
  parameter int LIGHT_RST = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BCD_W-1:0]   bcd_in,
  input  logic               bcd_valid,
  output logic               bcd_ready,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [SCAN_W-1:0]  clk_copy,
  output logic [LIGHT_W-1:0] lighttag,
  output logic [BCD_W-1:0]   snum,
  output logic               frame_start
);
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;
  logic          tick;
  logic          boundary;
  bcd_word_t     pend;
  logic          pend_full;
  logic          up_press, down_press;

  assign tick     = (pcnt == P_LAST);
  assign boundary = tick && (clk_copy == SCAN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_copy    <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick) clk_copy <= clk_copy + 1'b1;
    end
  end

  // Handshake: a word transfers on any clk edge where bcd_valid && bcd_ready;
  // bcd_ready is simply !pend_full, so the source must hold bcd_in/bcd_valid until then.
  assign bcd_ready = !pend_full;

  // A boundary drains pend into snum; it cannot also accept because ready is low while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      pend_full <= 1'b0;
      snum      <= '0;
    end else if (boundary && pend_full) begin
      snum      <= pend;
      pend_full <= 1'b0;
    end else if (bcd_valid && !pend_full) begin
      pend      <= bcd_in;
      pend_full <= 1'b1;
    end
  end

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .press (up_press)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .press (down_press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lighttag <= LIGHT_W'(LIGHT_RST);
    end else if (up_press && !down_press) begin
      if (lighttag != LIGHT_MAX) lighttag <= lighttag + 1'b1;
    end else if (down_press && !up_press) begin
      if (lighttag != '0) lighttag <= lighttag - 1'b1;
    end
  end
endmodule

// File: tb/tb_disp_scan_gen.sv
// Randomized bench for disp_scan_gen against a cycle-count based reference model.
module tb_disp_scan_gen;
  localparam int PRESCALE = 4;
  localparam int DEB_CYC  = 8;
  localparam int FRAME    = PRESCALE * 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = '0;
  logic        bcd_valid = 1'b0;
  logic        bcd_ready;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [5:0]  clk_copy;
  logic [3:0]  lighttag;
  logic [15:0] snum;
  logic        frame_start;

  int vectors = 0;
  int errors  = 0;

  // model state: edges since reset release and the word pipeline
  int          m_n = 0;
  logic        m_pf = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_snum = '0;
  int          m_light = 15;
  bit          lt_check = 1'b0;

  disp_scan_gen #(.PRESCALE(PRESCALE), .DEB_CYC(DEB_CYC), .LIGHT_RST(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .bcd_in      (bcd_in),
    .bcd_valid   (bcd_valid),
    .bcd_ready   (bcd_ready),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .clk_copy    (clk_copy),
    .lighttag    (lighttag),
    .snum        (snum),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Phase = edges/PRESCALE mod 64; frames end every 256 edges; a full pend drains there.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n = 0; m_pf = 1'b0; m_pend = '0; m_snum = '0;
    end else begin
      m_n = m_n + 1;
      if ((m_n % FRAME == 0) && m_pf) begin
        m_snum = m_pend; m_pf = 1'b0;
      end else if (bcd_valid && !m_pf) begin
        m_pend = bcd_in; m_pf = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("clk_copy", 32'(clk_copy), 32'((m_n / PRESCALE) % 64));
      check("frame_start", 32'(frame_start), 32'((m_n > 0) && (m_n % FRAME == 0)));
      check("snum", 32'(snum), 32'(m_snum));
      check("bcd_ready", 32'(bcd_ready), 32'(!m_pf));
      if (lt_check) check("lighttag", 32'(lighttag), 32'(m_light));
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_phase(input int p);
    int k = 0;
    while (!(((m_n / PRESCALE) % 64 == p) && (m_n % PRESCALE == 0)) && k < 2000) begin
      step(1); k++;
    end
    check("wait_phase_timeout", 32'(k < 2000), 32'd1);
  endtask

  task automatic send(input logic [15:0] w);
    logic r;
    int   k = 0;
    bcd_in = w; bcd_valid = 1'b1;
    do begin
      r = bcd_ready;
      step(1); k++;
    end while (!r && k < 1000);
    check("send_timeout", 32'(r), 32'd1);
    bcd_valid = 1'b0;
    bcd_in = 16'($urandom);
  endtask

  task automatic press(input bit up, input bit down);
    lt_check = 1'b0;
    btn_up = up; btn_down = down;
    step(DEB_CYC + 6);
    btn_up = 1'b0; btn_down = 1'b0;
    step(DEB_CYC + 6);
    if (up && !down && m_light < 15) m_light++;
    if (down && !up && m_light > 0) m_light--;
    lt_check = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    m_light = 15;
    rst = 1'b0;
    lt_check = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    check("rst_clk_copy", 32'(clk_copy), 32'd0);
    check("rst_lighttag", 32'(lighttag), 32'd15);
    check("rst_snum", 32'(snum), 32'd0);
    check("rst_bcd_ready", 32'(bcd_ready), 32'd1);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    do_reset();

    // frame-aligned update from phase 10
    wait_phase(10);
    check("phase10_lit", 32'(clk_copy), 32'd10);
    send(16'h1234);
    check("ready_drop", 32'(bcd_ready), 32'd0);
    step(FRAME - 1 - m_n);
    check("pre_wrap_snum", 32'(snum), 32'd0);
    step(1);
    check("wrap_snum_lit", 32'(snum), 32'h1234);
    check("wrap_frame_start_lit", 32'(frame_start), 32'd1);
    check("wrap_clk_copy_lit", 32'(clk_copy), 32'd0);
    step(1);
    check("ready_back_lit", 32'(bcd_ready), 32'd1);

    // backpressure: 9999 waits behind 5678
    send(16'h5678);
    send(16'h9999);
    wait_phase(1);
    check("bp_snum_5678_lit", 32'(snum), 32'h5678);
    wait_phase(63);
    wait_phase(0);
    check("bp_snum_9999_lit", 32'(snum), 32'h9999);

    // random words with random gaps
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 300));
      send(16'($urandom));
    end
    step(2 * FRAME);

    // brightness saturation, simultaneous presses, bounce rejection
    lt_check = 1'b1;
    for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
    check("sat_high_lit", 32'(lighttag), 32'd15);
    for (int i = 0; i < 16; i++) press(1'b0, 1'b1);
    check("sat_low_lit", 32'(lighttag), 32'd0);
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("both_lit", 32'(lighttag), 32'd3);
    lt_check = 1'b0;
    for (int i = 0; i < 40; i += 3) begin
      btn_up = ~btn_up;
      step(3);
    end
    btn_up = 1'b0;
    step(DEB_CYC + 6);
    check("bounce_none_lit", 32'(lighttag), 32'd3);
    press(1'b1, 1'b0);
    check("bounce_one_lit", 32'(lighttag), 32'd4);

    // async reset at phase 37 with a word pending
    wait_phase(30);
    send(16'hABCD);
    wait_phase(37);
    check("pend_full_before_rst", 32'(bcd_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("async_clk_copy", 32'(clk_copy), 32'd0);
    check("async_snum", 32'(snum), 32'd0);
    check("async_lighttag", 32'(lighttag), 32'd15);
    check("async_bcd_ready", 32'(bcd_ready), 32'd1);
    check("async_frame_start", 32'(frame_start), 32'd0);
    step(1);
    do_reset();
    step(FRAME + 10);
    check("no_stale_word_lit", 32'(snum), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
